puf_resp_uart_framer: RTL and testbench

// - Host-bound feeder for the UART transmit port: accepts one wide PUF response word and emits it as a framed byte stream.
// - Drives the UART's transmit / tx_byte / is_transmitting handshake, one byte at a time.
// - Frame layout: HEADER byte, then response bytes LSB-first, then an optional XOR checksum byte.
// - Sits between the PUF response register and the UART.

---
 rtl/puf_resp_uart_framer.sv | 148 ++++++++++++++
 tb/tb_puf_resp_uart_framer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_resp_uart_framer.sv
// puf_resp_uart_framer: takes one wide PUF response word and sends it to the
// UART as a framed byte stream. The frame is HEADER, then the response bytes
// LSB-first, then an optional XOR checksum byte.
// Optional feature macro: PUF_FRAMER_CHECKSUM_EN adds the trailing checksum byte.
// The framer issues one byte at a time. It waits for the UART to report busy,
// then waits for it to go idle again before it requests the next byte.
module puf_resp_uart_framer #(
    parameter int          DATA_BYTES = 16,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_resp_valid,
    input  logic [DATA_BYTES*8-1:0] i_resp_data,
    output logic                    o_resp_ready,
    output logic                    o_uart_transmit,
    output logic [7:0]              o_uart_tx_byte,
    input  logic                    i_uart_is_transmitting,
    output logic                    o_busy,
    output logic                    o_frame_done,
    output logic [15:0]             o_frame_count
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACK,
        DRAIN,
        DONE
    } state_t;

    localparam logic [7:0] LAST_DATA = 8'(DATA_BYTES);

    state_t                  r_state;
    state_t                  w_next;
    logic [DATA_BYTES*8-1:0] r_shift;
    logic [7:0]              r_idx;
    logic                    r_hdr_sent;
    logic [7:0]              r_tx_byte;
    logic [15:0]             r_frame_count;
`ifdef PUF_FRAMER_CHECKSUM_EN
    logic [7:0]              r_csum;
    logic                    r_cs_sent;
`endif

    logic       w_accept;
    logic       w_issue;
    logic       w_is_data;
    logic       w_last_sent;
    logic [7:0] w_cur_byte;

    assign w_accept  = i_resp_valid && (r_state == IDLE);
    assign w_issue   = (r_state == REQ) && !i_uart_is_transmitting;
    assign w_is_data = r_hdr_sent && (r_idx != LAST_DATA);

`ifdef PUF_FRAMER_CHECKSUM_EN
    assign w_last_sent = r_cs_sent;
`else
    assign w_last_sent = r_hdr_sent && (r_idx == LAST_DATA);
`endif

    // Select the byte that goes out next: header first, then data, then checksum
    always_comb begin
        w_cur_byte = HEADER;
        if (w_is_data) begin
            w_cur_byte = r_shift[7:0];
        end
`ifdef PUF_FRAMER_CHECKSUM_EN
        else if (r_hdr_sent) begin
            w_cur_byte = r_csum;
        end
`endif
    end

    // Hold the FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Compute the next state from the UART handshake and the byte position
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = REQ;
            REQ:     if (!i_uart_is_transmitting) w_next = ACK;
            ACK:     if (i_uart_is_transmitting) w_next = DRAIN;
            DRAIN:   if (!i_uart_is_transmitting) w_next = w_last_sent ? DONE : REQ;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Load the word on accept, then advance the shift register and checksum as bytes go out
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift    <= '0;
            r_idx      <= '0;
            r_hdr_sent <= 1'b0;
            r_tx_byte  <= 8'h00;
`ifdef PUF_FRAMER_CHECKSUM_EN
            r_csum     <= 8'h00;
            r_cs_sent  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_shift    <= i_resp_data;
            r_idx      <= '0;
            r_hdr_sent <= 1'b0;
`ifdef PUF_FRAMER_CHECKSUM_EN
            r_csum     <= HEADER;
            r_cs_sent  <= 1'b0;
`endif
        end else if (w_issue) begin
            r_tx_byte <= w_cur_byte;
            if (!r_hdr_sent) begin
                r_hdr_sent <= 1'b1;
            end else if (w_is_data) begin
                r_shift <= r_shift >> 8;
                r_idx   <= r_idx + 8'd1;
`ifdef PUF_FRAMER_CHECKSUM_EN
                r_csum  <= r_csum ^ r_shift[7:0];
            end else begin
                r_cs_sent <= 1'b1;
`endif
            end
        end
    end

    // Count completed frames; the counter wraps naturally at 16 bits
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_count <= 16'h0000;
        end else if (r_state == DONE) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign o_resp_ready    = (r_state == IDLE);
    assign o_busy          = (r_state != IDLE);
    assign o_frame_done    = (r_state == DONE);
    assign o_uart_transmit = w_issue;
    assign o_uart_tx_byte  = w_issue ? w_cur_byte : r_tx_byte;
    assign o_frame_count   = r_frame_count;

endmodule

// File: tb/tb_puf_resp_uart_framer.sv
// Testbench for puf_resp_uart_framer with DATA_BYTES=4.
// A behavioural UART raises is_transmitting one cycle after a transmit request
// and keeps it high for 40 cycles. The expected byte streams are built from
// the frame layout with plain arithmetic.
module tb_puf_resp_uart_framer;

    localparam int         NB  = 4;
    localparam logic [7:0] HDR = 8'hA5;

    logic          clk = 1'b0;
    logic          rstN;
    logic          respValid;
    logic [NB*8-1:0] respData;
    logic          respReady;
    logic          uartTransmit;
    logic [7:0]    uartTxByte;
    logic          uartIsTransmitting;
    logic          busy;
    logic          frameDone;
    logic [15:0]   frameCount;

    logic          uartIsTx = 1'b0;
    int            uartCnt  = 0;
    logic          extBusy  = 1'b0;
    logic          prevTx   = 1'b0;
    logic [7:0]    txQ[$];
    logic [7:0]    expQ[$];
    int            doneCount  = 0;
    int            violations = 0;
    int            checks     = 0;
    int            errors     = 0;
    int            expCount   = 0;

    assign uartIsTransmitting = uartIsTx | extBusy;

    always #5 clk = ~clk;

    puf_resp_uart_framer #(.DATA_BYTES(NB), .HEADER(HDR)) dut (
        .i_clk                  (clk),
        .i_rst_n                (rstN),
        .i_resp_valid           (respValid),
        .i_resp_data            (respData),
        .o_resp_ready           (respReady),
        .o_uart_transmit        (uartTransmit),
        .o_uart_tx_byte         (uartTxByte),
        .i_uart_is_transmitting (uartIsTransmitting),
        .o_busy                 (busy),
        .o_frame_done           (frameDone),
        .o_frame_count          (frameCount)
    );

    // The UART model captures each requested byte and stays busy for 40 cycles.
    // Reset does not touch it, so a byte already in flight finishes on the line.
    always @(posedge clk) begin
        if (uartTransmit) begin
            txQ.push_back(uartTxByte);
            uartIsTx <= 1'b1;
            uartCnt  <= 40;
        end else if (uartCnt > 1) begin
            uartCnt <= uartCnt - 1;
        end else begin
            uartCnt  <= 0;
            uartIsTx <= 1'b0;
        end
    end

    // Record handshake rule violations and count frame_done pulses
    always @(posedge clk) begin
        if (uartTransmit && uartIsTransmitting) violations++;
        if (uartTransmit && prevTx) violations++;
        prevTx <= uartTransmit;
        if (frameDone) doneCount++;
    end

    // Append the expected frame for one word: header, bytes LSB-first, optional XOR
    task automatic buildExpected(input logic [NB*8-1:0] w);
        logic [7:0] cs;
        cs = HDR;
        expQ.push_back(HDR);
        for (int i = 0; i < NB; i++) begin
            expQ.push_back(w[8*i +: 8]);
            cs = cs ^ w[8*i +: 8];
        end
`ifdef PUF_FRAMER_CHECKSUM_EN
        expQ.push_back(cs);
`endif
    endtask

    // Present one word for a single cycle while the framer is idle
    task automatic sendWord(input logic [NB*8-1:0] w);
        @(negedge clk);
        respValid = 1'b1;
        respData  = w;
        @(negedge clk);
        respValid = 1'b0;
    endtask

    // Wait, within a cycle budget, until frame_done has pulsed past a start count
    task automatic waitDone(input int startDone, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (doneCount > startDone) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rstN      = 1'b0;
        respValid = 1'b0;
        respData  = '0;
        repeat (3) @(negedge clk);
        checks++; if (respReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", respReady); end
        checks++; if (uartTransmit !== 1'b0) begin errors++; $display("[TB] FAIL reset_transmit: got %b expected 0", uartTransmit); end
        checks++; if (uartTxByte !== 8'h00) begin errors++; $display("[TB] FAIL reset_txbyte: got %h expected 00", uartTxByte); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (frameDone !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", frameDone); end
        checks++; if (frameCount !== 16'h0) begin errors++; $display("[TB] FAIL reset_count: got %h expected 0000", frameCount); end
        rstN = 1'b1;
        repeat (100) @(negedge clk);
        checks++; if (txQ.size() != 0) begin errors++; $display("[TB] FAIL idle_no_tx: got %0d bytes expected 0", txQ.size()); end
        checks++; if (respReady !== 1'b1) begin errors++; $display("[TB] FAIL idle_ready: got %b expected 1", respReady); end
    endtask

    task automatic test_known_frame;
        logic [7:0] known[$];
        bit ok;
        int startDone;
`ifdef PUF_FRAMER_CHECKSUM_EN
        known = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hE1};
`else
        known = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44};
`endif
        startDone = doneCount;
        sendWord(32'h44332211);
        checks++; if (uartTransmit !== 1'b1 || uartTxByte !== HDR) begin
            errors++; $display("[TB] FAIL latency_header: got tx=%b byte=%h expected tx=1 byte=%h", uartTransmit, uartTxByte, HDR);
        end
        waitDone(startDone, 3000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL known_done: got timeout expected frame_done"); end
        checks++;
        if (txQ.size() != known.size()) begin
            errors++; $display("[TB] FAIL known_len: got %0d expected %0d", txQ.size(), known.size());
        end else begin
            for (int i = 0; i < known.size(); i++) begin
                checks++;
                if (txQ[i] !== known[i]) begin errors++; $display("[TB] FAIL known_byte%0d: got %h expected %h", i, txQ[i], known[i]); end
            end
        end
        expCount++;
        checks++; if (doneCount - startDone != 1) begin errors++; $display("[TB] FAIL known_pulses: got %0d expected 1", doneCount - startDone); end
        checks++; if (frameCount !== 16'(expCount)) begin errors++; $display("[TB] FAIL known_count: got %0d expected %0d", frameCount, expCount); end
        txQ.delete();
    endtask

    task automatic test_random_frames;
        bit ok;
        int startDone;
        logic [NB*8-1:0] w;
        for (int n = 0; n < 3; n++) begin
            w = $urandom;
            expQ.delete();
            buildExpected(w);
            startDone = doneCount;
            sendWord(w);
            waitDone(startDone, 3000, ok);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL rand%0d_done: got timeout expected frame_done", n); end
            checks++;
            if (txQ.size() != expQ.size()) begin
                errors++; $display("[TB] FAIL rand%0d_len: got %0d expected %0d", n, txQ.size(), expQ.size());
            end else begin
                for (int i = 0; i < expQ.size(); i++) begin
                    checks++;
                    if (txQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL rand%0d_byte%0d: got %h expected %h", n, i, txQ[i], expQ[i]); end
                end
            end
            expCount++;
            checks++; if (frameCount !== 16'(expCount)) begin errors++; $display("[TB] FAIL rand%0d_count: got %0d expected %0d", n, frameCount, expCount); end
            txQ.delete();
        end
    endtask

    task automatic test_back_to_back;
        int startDone;
        int nAcc;
        bit finished;
        nAcc = 0;
        finished = 1'b0;
        startDone = doneCount;
        expQ.delete();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (nAcc < 2) begin
                respValid = 1'b1;
                respData  = $urandom;
                if (respReady) begin
                    if (nAcc == 1) begin
                        checks++; if (doneCount - startDone != 1) begin errors++; $display("[TB] FAIL b2b_second_accept: got %0d frames done expected 1", doneCount - startDone); end
                    end
                    buildExpected(respData);
                    nAcc++;
                end
            end else begin
                respValid = 1'b0;
            end
            if (doneCount - startDone >= 2) begin
                finished = 1'b1;
                break;
            end
        end
        respValid = 1'b0;
        checks++; if (!finished) begin errors++; $display("[TB] FAIL b2b_done: got timeout expected two frames"); end
        repeat (100) @(negedge clk);
        checks++; if (doneCount - startDone != 2) begin errors++; $display("[TB] FAIL b2b_frames: got %0d expected 2", doneCount - startDone); end
        checks++;
        if (txQ.size() != expQ.size()) begin
            errors++; $display("[TB] FAIL b2b_len: got %0d expected %0d", txQ.size(), expQ.size());
        end else begin
            for (int i = 0; i < expQ.size(); i++) begin
                checks++;
                if (txQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL b2b_byte%0d: got %h expected %h", i, txQ[i], expQ[i]); end
            end
        end
        expCount += 2;
        checks++; if (frameCount !== 16'(expCount)) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected %0d", frameCount, expCount); end
        txQ.delete();
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        bit reached;
        int startDone;
        logic [NB*8-1:0] w;
        reached = 1'b0;
        startDone = doneCount;
        sendWord($urandom);
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (txQ.size() >= 3) begin
                reached = 1'b1;
                break;
            end
        end
        checks++; if (!reached) begin errors++; $display("[TB] FAIL midrst_third_byte: got timeout expected third byte"); end
        #2 rstN = 1'b0;
        #1;
        checks++; if (respReady !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ready_busy: got %b/%b expected 1/0", respReady, busy); end
        checks++; if (uartTransmit !== 1'b0 || uartTxByte !== 8'h00) begin errors++; $display("[TB] FAIL midrst_uart: got %b/%h expected 0/00", uartTransmit, uartTxByte); end
        checks++; if (frameDone !== 1'b0 || frameCount !== 16'h0) begin errors++; $display("[TB] FAIL midrst_done_count: got %b/%h expected 0/0000", frameDone, frameCount); end
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        repeat (60) @(negedge clk);
        checks++; if (doneCount != startDone) begin errors++; $display("[TB] FAIL midrst_no_done: got %0d pulses expected 0", doneCount - startDone); end
        expCount = 0;
        txQ.delete();
        w = $urandom;
        expQ.delete();
        buildExpected(w);
        sendWord(w);
        waitDone(startDone, 3000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL midrst_next_done: got timeout expected frame_done"); end
        checks++;
        if (txQ.size() != expQ.size()) begin
            errors++; $display("[TB] FAIL midrst_len: got %0d expected %0d", txQ.size(), expQ.size());
        end else begin
            for (int i = 0; i < expQ.size(); i++) begin
                checks++;
                if (txQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL midrst_byte%0d: got %h expected %h", i, txQ[i], expQ[i]); end
            end
        end
        expCount++;
        checks++; if (frameCount !== 16'(expCount)) begin errors++; $display("[TB] FAIL midrst_count: got %0d expected %0d", frameCount, expCount); end
        txQ.delete();
    endtask

    task automatic test_uart_busy_at_accept;
        bit ok;
        int startDone;
        logic [NB*8-1:0] w;
        w = $urandom;
        expQ.delete();
        buildExpected(w);
        startDone = doneCount;
        @(negedge clk);
        extBusy = 1'b1;
        sendWord(w);
        repeat (200) @(negedge clk);
        checks++; if (txQ.size() != 0) begin errors++; $display("[TB] FAIL busy_hold_tx: got %0d bytes expected 0", txQ.size()); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_hold_state: got %b expected 1", busy); end
        extBusy = 1'b0;
        waitDone(startDone, 3000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL busy_done: got timeout expected frame_done"); end
        checks++;
        if (txQ.size() != expQ.size()) begin
            errors++; $display("[TB] FAIL busy_len: got %0d expected %0d", txQ.size(), expQ.size());
        end else begin
            for (int i = 0; i < expQ.size(); i++) begin
                checks++;
                if (txQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL busy_byte%0d: got %h expected %h", i, txQ[i], expQ[i]); end
            end
        end
        expCount++;
        checks++; if (frameCount !== 16'(expCount)) begin errors++; $display("[TB] FAIL busy_count: got %0d expected %0d", frameCount, expCount); end
        txQ.delete();
    endtask

    task automatic test_count_wrap;
        bit ok;
        int startDone;
        @(negedge clk);
        force dut.r_frame_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_frame_count;
        startDone = doneCount;
        sendWord($urandom);
        waitDone(startDone, 3000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL wrap_done: got timeout expected frame_done"); end
        checks++; if (frameCount !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_count: got %h expected 0000", frameCount); end
        txQ.delete();
    endtask

    task automatic test_protocol;
        checks++; if (violations != 0) begin errors++; $display("[TB] FAIL uart_handshake: got %0d violations expected 0", violations); end
    endtask

    initial begin
        test_reset();
        test_known_frame();
        test_random_frames();
        test_back_to_back();
        test_reset_mid_frame();
        test_uart_busy_at_accept();
        test_count_wrap();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
